// File: rtl/cpu_ctrl.sv
// Fetch/decode/execute sequencer for the model CPU.
// Optional single-step mode: define CU_SINGLE_STEP_EN to add the step port and return to IDLE after each instruction.
module cpu_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mem_ack,
`ifdef CU_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic             LD,
    input  logic             ADD,
    input  logic             SUB,
    input  logic             AND,
    input  logic             OR,
    input  logic             HALT,
    output logic             mem_rd,
    output logic             addr_sel,
    output logic             IPC,
    output logic             IIR,
    output logic             acc_ld,
    output logic [2:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOADIR,
        S_DECODE,
        S_OPER,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       n_lines;
    logic [2:0]       op_code;
    logic             go;

    always_comb begin
        n_lines = 3'(LD) + 3'(ADD) + 3'(SUB) + 3'(AND) + 3'(OR) + 3'(HALT);
`ifdef CU_SINGLE_STEP_EN
        go = start | step;
`else
        go = start;
`endif
        // Only consulted when exactly one operation line is set.
        if (ADD)      op_code = 3'b001;
        else if (SUB) op_code = 3'b010;
        else if (AND) op_code = 3'b011;
        else if (OR)  op_code = 3'b100;
        else          op_code = 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            alu_op_q  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            alu_op_q  <= alu_op_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        alu_op_d  = alu_op_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE:   if (go) state_d = S_FETCH;
            S_FETCH:  if (mem_ack) state_d = S_LOADIR;
            S_LOADIR: state_d = S_DECODE;
            S_DECODE: begin
                if (n_lines == 3'd1 && !HALT) begin
                    alu_op_d = op_code;
                    state_d  = S_OPER;
                end else if (n_lines == 3'd1) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_HALTED;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALTED;
                end
            end
            S_OPER:   if (mem_ack) state_d = S_EXEC;
            S_EXEC: begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef CU_SINGLE_STEP_EN
                state_d = S_IDLE;
`else
                state_d = S_FETCH;
`endif
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = (state_q == S_FETCH) || (state_q == S_OPER);
        addr_sel  = (state_q == S_OPER);
        IIR       = (state_q == S_LOADIR);
        IPC       = (state_q == S_LOADIR);
        acc_ld    = (state_q == S_EXEC);
        halted    = (state_q == S_HALTED);
        alu_op    = alu_op_q;
        illegal   = illegal_q;
        instr_cnt = cnt_q;
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl (default build): random instruction programs are expanded into
// per-cycle stimulus and expected-output timelines, then replayed against the DUT.
module tb_cpu_ctrl;

    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             mem_ack = 1'b0;
    logic [5:0]       dec = '0;
    logic             mem_rd, addr_sel, IPC, IIR, acc_ld, halted, illegal;
    logic [2:0]       alu_op;
    logic [CNT_W-1:0] instr_cnt;

    cpu_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_ack(mem_ack),
        .LD(dec[5]), .ADD(dec[4]), .SUB(dec[3]), .AND(dec[2]), .OR(dec[1]), .HALT(dec[0]),
        .mem_rd(mem_rd), .addr_sel(addr_sel), .IPC(IPC), .IIR(IIR), .acc_ld(acc_ld),
        .alu_op(alu_op), .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       ack;
        logic [5:0] dec;
    } stim_t;

    stim_t            stim_q[$];
    logic [31:0]      exp_q[$];
    logic [2:0]       m_alu;
    logic [CNT_W-1:0] m_cnt;
    logic             m_ill;
    int               abort_idx;
    int unsigned      n_checks = 0;
    int unsigned      n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bit order: mem_rd addr_sel IPC IIR acc_ld halted illegal alu_op instr_cnt
    function automatic logic [31:0] pack(input logic mrd, input logic asel, input logic ipc,
                                         input logic iir, input logic acc, input logic hlt,
                                         input logic ill, input logic [2:0] alu,
                                         input logic [CNT_W-1:0] cnt);
        return 32'({mrd, asel, ipc, iir, acc, hlt, ill, alu, cnt});
    endfunction

    function automatic logic [31:0] observed();
        return pack(mem_rd, addr_sel, IPC, IIR, acc_ld, halted, illegal, alu_op, instr_cnt);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rdec();
        return 6'($urandom);
    endfunction

    task automatic emit(input logic mrd, input logic asel, input logic ld_ir, input logic acc,
                        input logic hlt, input logic s, input logic ack, input logic [5:0] d);
        exp_q.push_back(pack(mrd, asel, ld_ir, ld_ir, acc, hlt, m_ill, m_alu, m_cnt));
        stim_q.push_back('{start: s, ack: ack, dec: d});
    endtask

    // op: 0..4 = LD ADD SUB AND OR, 5 = HALT, 6 = no line, 7 = random multi-line, 8 = ADD+SUB
    task automatic gen_instr(input int op, input int fw, input int ow);
        logic [5:0] dv;
        for (int i = 0; i < fw; i++) emit(1, 0, 0, 0, 0, rb(), 1'b0, rdec());
        emit(1, 0, 0, 0, 0, rb(), 1'b1, rdec());
        emit(0, 0, 1, 0, 0, rb(), rb(), rdec());
        if (op < 5)       dv = 6'b100000 >> op;
        else if (op == 5) dv = 6'b000001;
        else if (op == 6) dv = 6'b000000;
        else if (op == 8) dv = 6'b011000;
        else begin
            do dv = rdec(); while ($countones(dv) < 2);
        end
        emit(0, 0, 0, 0, 0, rb(), rb(), dv);
        if (op < 5) begin
            m_alu = 3'(op);
            abort_idx = exp_q.size();
            for (int i = 0; i < ow; i++) emit(1, 1, 0, 0, 0, rb(), 1'b0, rdec());
            emit(1, 1, 0, 0, 0, rb(), 1'b1, rdec());
            emit(0, 0, 0, 1, 0, rb(), rb(), rdec());
            m_cnt = m_cnt + 1'b1;
        end else if (op == 5) begin
            m_cnt = m_cnt + 1'b1;
        end else begin
            m_ill = 1'b1;
        end
    endtask

    task automatic gen_halted(input int n);
        for (int i = 0; i < n; i++) emit(0, 0, 0, 0, 1, rb(), rb(), rdec());
    endtask

    task automatic gen_idle_start();
        int n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) emit(0, 0, 0, 0, 0, 1'b0, rb(), rdec());
        emit(0, 0, 0, 0, 0, 1'b1, rb(), rdec());
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        start = 1'b0;
        #1 check("rst_async", observed(), pack(0, 0, 0, 0, 0, 0, 0, 3'b000, '0));
        @(posedge clk);
        #1 rst = 1'b0;
        m_alu = '0;
        m_cnt = '0;
        m_ill = 1'b0;
        #1;
    endtask

    task automatic replay(input int round);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("r%0d_c%0d", round, i), observed(), exp_q[i]);
            start   = stim_q[i].start;
            mem_ack = stim_q[i].ack;
            dec     = stim_q[i].dec;
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        stim_q.delete();
    endtask

    initial begin
        m_alu = '0;
        m_cnt = '0;
        m_ill = 1'b0;
        abort_idx = 0;
        #12 rst = 1'b0;
        #1;
        check("rst_init", observed(), pack(0, 0, 0, 0, 0, 0, 0, 3'b000, '0));

        // LD, ADD, SUB, AND, OR, HALT with zero-wait memory
        gen_idle_start();
        for (int op = 0; op < 5; op++) gen_instr(op, 0, 0);
        gen_instr(5, 0, 0);
        gen_halted(5);
        replay(0);

        // Wait states 3/2, then ADD+SUB illegal decode
        do_reset();
        gen_idle_start();
        gen_instr(0, 3, 2);
        gen_instr(8, 0, 0);
        gen_halted(4);
        replay(1);

        // No decode line at all
        do_reset();
        gen_idle_start();
        gen_instr(6, 1, 0);
        gen_halted(3);
        replay(2);

        // Reset while OPER is waiting on memory
        do_reset();
        gen_idle_start();
        gen_instr(0, 0, 0);
        gen_instr(1, 0, 8);
        while (exp_q.size() > abort_idx + 1) begin
            void'(exp_q.pop_back());
            void'(stim_q.pop_back());
        end
        replay(3);
        mem_ack = 1'b0;

        for (int r = 4; r < 14; r++) begin
            int n;
            do_reset();
            gen_idle_start();
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++)
                gen_instr($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
            gen_instr($urandom_range(5, 7), $urandom_range(0, 2), 0);
            gen_halted(3);
            replay(r);
        end

        do_reset();
        check("rst_final", observed(), pack(0, 0, 0, 0, 0, 0, 0, 3'b000, '0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
